// File: rtl/calc_entry_fsm_if.sv
// Key-entry bus between the keypad decoder and the calculator entry FSM.
// The master drives the key strobe; the slave presents the operands and status.
interface calc_entry_fsm_if;
    logic       key_valid;
    logic [1:0] key_type;
    logic [3:0] key_val;
    logic [3:0] operand1;
    logic [3:0] operand2;
    logic [2:0] md_operator;
    logic       show_res;
    logic       err;
    logic       err_flag;
    logic [2:0] state;

    modport master (
        output key_valid, key_type, key_val,
        input  operand1, operand2, md_operator, show_res, err, err_flag, state
    );

    modport slave (
        input  key_valid, key_type, key_val,
        output operand1, operand2, md_operator, show_res, err, err_flag, state
    );
endinterface

// File: rtl/calc_entry_fsm.sv
// Calculator key-entry FSM: collects operand/operator/equals keys into an
// expression for the calculator core and flags keys that cannot be accepted.
module calc_entry_fsm (
    input  logic              clk,
    input  logic              sof_reset,
    calc_entry_fsm_if.slave   bus
);

    localparam logic [2:0] ST_IDLE = 3'b000;
    localparam logic [2:0] ST_OP1  = 3'b001;
    localparam logic [2:0] ST_OPR  = 3'b010;
    localparam logic [2:0] ST_OP2  = 3'b011;
    localparam logic [2:0] ST_SHOW = 3'b100;

    localparam logic [1:0] KEY_OPERAND  = 2'b00;
    localparam logic [1:0] KEY_OPERATOR = 2'b01;
    localparam logic [1:0] KEY_EQUALS   = 2'b10;
    localparam logic [1:0] KEY_CLEAR    = 2'b11;

    localparam logic [2:0] OPC_ADD     = 3'b000;
    localparam logic [2:0] OPC_DIV     = 3'b011;
    localparam logic [2:0] OPC_MOD     = 3'b100;
    localparam logic [2:0] OPC_SQUARE  = 3'b101;
    localparam logic [2:0] OPC_FACT    = 3'b110;
    localparam logic [2:0] OPC_INVALID = 3'b111;

    logic [2:0] state_q,       state_n;
    logic [3:0] operand1_q,    operand1_n;
    logic [3:0] operand2_q,    operand2_n;
    logic [2:0] md_operator_q, md_operator_n;
    logic       show_res_q,    show_res_n;
    logic       err_q,         err_n;
    logic       err_flag_q,    err_flag_n;

    logic [2:0] key_opc;
    logic       key_opc_ok;

    assign key_opc    = bus.key_val[2:0];
    assign key_opc_ok = (key_opc != OPC_INVALID);

    function automatic logic is_unary(input logic [2:0] opc);
        return (opc == OPC_SQUARE) || (opc == OPC_FACT);
    endfunction

    // Divide/modulo by zero and factorials that overflow the core are refused at equals.
    function automatic logic equals_rejected(input logic [2:0] opc,
                                             input logic [3:0] a,
                                             input logic [3:0] b);
        return (((opc == OPC_DIV) || (opc == OPC_MOD)) && (b == 4'd0)) ||
               ((opc == OPC_FACT) && (a > 4'd5));
    endfunction

    always_comb begin
        state_n       = state_q;
        operand1_n    = operand1_q;
        operand2_n    = operand2_q;
        md_operator_n = md_operator_q;
        show_res_n    = show_res_q;
        err_n         = 1'b0;
        err_flag_n    = err_flag_q;

        if (state_q > ST_SHOW) begin
            state_n    = ST_IDLE;
            show_res_n = 1'b0;
        end else if (bus.key_valid && (bus.key_type == KEY_CLEAR)) begin
            state_n       = ST_IDLE;
            operand1_n    = 4'd0;
            operand2_n    = 4'd0;
            md_operator_n = OPC_ADD;
            show_res_n    = 1'b0;
            err_flag_n    = 1'b0;
        end else if (bus.key_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.key_type == KEY_OPERAND) begin
                        operand1_n = bus.key_val;
                        operand2_n = 4'd0;
                        err_flag_n = 1'b0;
                        state_n    = ST_OP1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                ST_OP1: begin
                    if (bus.key_type == KEY_OPERAND) begin
                        operand1_n = bus.key_val;
                    end else if ((bus.key_type == KEY_OPERATOR) && key_opc_ok) begin
                        md_operator_n = key_opc;
                        if (is_unary(key_opc))
                            operand2_n = 4'd0;
                        state_n = ST_OPR;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                ST_OPR: begin
                    if (bus.key_type == KEY_OPERAND) begin
                        if (is_unary(md_operator_q)) begin
                            err_n = 1'b1;
                        end else begin
                            operand2_n = bus.key_val;
                            state_n    = ST_OP2;
                        end
                    end else if (bus.key_type == KEY_OPERATOR) begin
                        if (key_opc_ok) begin
                            md_operator_n = key_opc;
                            if (is_unary(key_opc))
                                operand2_n = 4'd0;
                        end else begin
                            err_n = 1'b1;
                        end
                    end else begin
                        // Equals is only meaningful here once a unary operator is chosen.
                        if (is_unary(md_operator_q) &&
                            !equals_rejected(md_operator_q, operand1_q, operand2_q)) begin
                            state_n    = ST_SHOW;
                            show_res_n = 1'b1;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end
                ST_OP2: begin
                    if (bus.key_type == KEY_OPERAND) begin
                        operand2_n = bus.key_val;
                    end else if (bus.key_type == KEY_EQUALS) begin
                        if (equals_rejected(md_operator_q, operand1_q, operand2_q)) begin
                            err_n = 1'b1;
                        end else begin
                            state_n    = ST_SHOW;
                            show_res_n = 1'b1;
                        end
                    end else begin
                        err_n = 1'b1;
                    end
                end
                ST_SHOW: begin
                    // A fresh operand starts the next expression; other keys leave the result up.
                    if (bus.key_type == KEY_OPERAND) begin
                        operand1_n    = bus.key_val;
                        operand2_n    = 4'd0;
                        md_operator_n = OPC_ADD;
                        show_res_n    = 1'b0;
                        err_flag_n    = 1'b0;
                        state_n       = ST_OP1;
                    end
                end
                default: begin
                    state_n    = ST_IDLE;
                    show_res_n = 1'b0;
                end
            endcase
        end

        if (err_n)
            err_flag_n = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (sof_reset) begin
            state_q       <= ST_IDLE;
            operand1_q    <= 4'd0;
            operand2_q    <= 4'd0;
            md_operator_q <= OPC_ADD;
            show_res_q    <= 1'b0;
            err_q         <= 1'b0;
            err_flag_q    <= 1'b0;
        end else begin
            state_q       <= state_n;
            operand1_q    <= operand1_n;
            operand2_q    <= operand2_n;
            md_operator_q <= md_operator_n;
            show_res_q    <= show_res_n;
            err_q         <= err_n;
            err_flag_q    <= err_flag_n;
        end
    end

    assign bus.state       = state_q;
    assign bus.operand1    = operand1_q;
    assign bus.operand2    = operand2_q;
    assign bus.md_operator = md_operator_q;
    assign bus.show_res    = show_res_q;
    assign bus.err         = err_q;
    assign bus.err_flag    = err_flag_q;

endmodule
